// File: rtl/led_row_scheduler_pkg.sv
// Shared types and constants for the LED row scheduler and its renderer.
package led_row_scheduler_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        COMMIT = 1'b1
    } sched_state_t;

    localparam int NREQ = 2;

    localparam logic [23:0] LED_COLOUR_ON  = 24'hFF2000;
    localparam logic [23:0] LED_COLOUR_OFF = 24'h100400;

endpackage

// File: rtl/led_row_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer flips to the other side after every transfer.
module rr_arb2
    import led_row_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] ready
);

    logic ptr;

    always_comb begin
        ready = '0;
        if (enable) begin
            case (valid)
                2'b01:   ready = 2'b01;
                2'b10:   ready = 2'b10;
                2'b11:   ready = ptr ? 2'b10 : 2'b01;
                default: ready = '0;
            endcase
        end
    end

    // ready is only ever raised alongside valid, so any grant is a transfer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= 1'b0;
        end else if (|ready) begin
            ptr <= ready[0];
        end
    end

endmodule

// File: rtl/led_row_scheduler.sv
// Double-buffered LED row store: requesters fill a shadow buffer that is copied to the live
// buffer during vblank, while the live row under the current display line is presented.
module led_row_scheduler
    import led_row_scheduler_pkg::*;
#(
    parameter int NROWS   = 6,
    parameter int HEIGHT  = 80,
    parameter int VACTIVE = 480
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        px_stb,
    input  logic [9:0]  x_px,
    input  logic [9:0]  y_px,
    input  logic [1:0]  req_valid,
    input  logic [5:0]  req_row,
    input  logic [15:0] req_byte,
    output logic [1:0]  req_ready,
    output logic [7:0]  byte_led,
    output logic [2:0]  row_led,
    output logic        frame_done,
    output logic        row_err
);

    localparam int LINE_W = $clog2(HEIGHT);

    sched_state_t      state, state_nxt;
    logic [2:0]        idx;
    logic [7:0]        shadow [NROWS];
    logic [7:0]        live   [NROWS];
    logic [NROWS-1:0]  dirty;
    logic [LINE_W-1:0] line_cnt;
    logic [2:0]        row_cnt;

    logic       sel;
    logic       xfer;
    logic       wr_ok;
    logic [2:0] wr_row;
    logic [7:0] wr_byte;
    logic       vblank;
    logic       commit_last;

    // Reset also gates the grant path so req_ready is low while rstn is held
    rr_arb2 u_arb (
        .clk    (clk),
        .rstn   (rstn),
        .enable (rstn && (state == RUN)),
        .valid  (req_valid),
        .ready  (req_ready)
    );

    always_comb begin
        sel         = req_ready[1];
        wr_row      = sel ? req_row[5:3]   : req_row[2:0];
        wr_byte     = sel ? req_byte[15:8] : req_byte[7:0];
        xfer        = |(req_valid & req_ready);
        wr_ok       = xfer && (32'(wr_row) < NROWS);
        vblank      = px_stb && (x_px == 10'd0) && (y_px == 10'(VACTIVE));
        commit_last = (state == COMMIT) && (32'(idx) == NROWS - 1);

        state_nxt = state;
        case (state)
            RUN:     if (vblank) state_nxt = COMMIT;
            COMMIT:  if (commit_last) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= RUN;
            idx        <= '0;
            frame_done <= 1'b0;
            row_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= (state == COMMIT && !commit_last) ? idx + 3'd1 : '0;
            frame_done <= commit_last;
            row_err    <= xfer && !wr_ok;
        end
    end

    // Writes and the commit copy never coincide: grants are withheld throughout COMMIT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NROWS; i++) begin
                shadow[i] <= '0;
                live[i]   <= '0;
            end
            dirty <= '0;
        end else begin
            if (wr_ok) begin
                shadow[wr_row] <= wr_byte;
                dirty[wr_row]  <= 1'b1;
            end
            if (state == COMMIT && dirty[idx]) begin
                live[idx]  <= shadow[idx];
                dirty[idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_cnt <= '0;
            row_cnt  <= '0;
        end else if (px_stb && x_px == 10'd0) begin
            if (y_px == 10'd0) begin
                line_cnt <= '0;
                row_cnt  <= '0;
            end else if (line_cnt == LINE_W'(HEIGHT - 1)) begin
                line_cnt <= '0;
                if (32'(row_cnt) != NROWS - 1) row_cnt <= row_cnt + 3'd1;
            end else begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_led  <= '0;
            byte_led <= '0;
        end else begin
            row_led  <= row_cnt;
            byte_led <= live[row_cnt];
        end
    end

endmodule

// File: tb/tb_led_row_scheduler.sv
// Scoreboard bench for led_row_scheduler: stimulus queues expected events, a monitor consumes them.
module tb_led_row_scheduler;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        px_stb = 1'b0;
    logic [9:0]  x_px = '0;
    logic [9:0]  y_px = '0;
    logic [1:0]  req_valid = '0;
    logic [5:0]  req_row = '0;
    logic [15:0] req_byte = '0;
    logic [1:0]  req_ready;
    logic [7:0]  byte_led;
    logic [2:0]  row_led;
    logic        frame_done;
    logic        row_err;

    typedef struct packed {
        logic [7:0] b;
        logic [2:0] r;
        logic [1:0] rdy;
        logic       fd;
        logic       err;
    } snap_t;

    logic [1:0] exp_grant [$];
    int         exp_gap   [$];
    int         exp_frame [$];
    int         exp_err   [$];
    snap_t      exp_snap  [$];

    int   tests = 0;
    int   fails = 0;
    int   gap   = 0;
    logic chk   = 1'b0;

    always #5 clk = ~clk;

    led_row_scheduler #(.NROWS(6), .HEIGHT(80), .VACTIVE(480)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .px_stb     (px_stb),
        .x_px       (x_px),
        .y_px       (y_px),
        .req_valid  (req_valid),
        .req_row    (req_row),
        .req_byte   (req_byte),
        .req_ready  (req_ready),
        .byte_led   (byte_led),
        .row_led    (row_led),
        .frame_done (frame_done),
        .row_err    (row_err)
    );

    always @(negedge clk) begin : monitor
        logic [1:0] eg;
        int         eq;
        snap_t      es;
        if (req_ready != 2'b00) begin
            if (gap > 0) begin
                tests++;
                if (exp_gap.size() == 0) begin
                    fails++;
                    $display("FAIL stall_gap: unexpected stall of %0d cycles", gap);
                end else begin
                    eq = exp_gap.pop_front();
                    if (eq != gap) begin
                        fails++;
                        $display("FAIL stall_gap: got %0d cycles, expected %0d", gap, eq);
                    end
                end
                gap = 0;
            end
            tests++;
            if (exp_grant.size() == 0) begin
                fails++;
                $display("FAIL grant: unexpected req_ready=%b", req_ready);
            end else begin
                eg = exp_grant.pop_front();
                if (eg !== req_ready) begin
                    fails++;
                    $display("FAIL grant: req_ready=%b expected %b", req_ready, eg);
                end
            end
        end else if (rstn && req_valid != 2'b00) begin
            gap++;
        end
        if (frame_done) begin
            tests++;
            if (exp_frame.size() == 0) begin
                fails++;
                $display("FAIL frame_done: unexpected pulse at %0t, expected none", $time);
            end else begin
                eq = exp_frame.pop_front();
            end
        end
        if (row_err) begin
            tests++;
            if (exp_err.size() == 0) begin
                fails++;
                $display("FAIL row_err: unexpected pulse at %0t, expected none", $time);
            end else begin
                eq = exp_err.pop_front();
            end
        end
        if (chk) begin
            tests++;
            if (exp_snap.size() == 0) begin
                fails++;
                $display("FAIL snapshot: no expected record queued");
            end else begin
                es = exp_snap.pop_front();
                if (es !== {byte_led, row_led, req_ready, frame_done, row_err}) begin
                    fails++;
                    $display("FAIL snapshot: byte=%h row=%0d rdy=%b fd=%b err=%b expected byte=%h row=%0d rdy=%b fd=%b err=%b",
                             byte_led, row_led, req_ready, frame_done, row_err,
                             es.b, es.r, es.rdy, es.fd, es.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_line(input int y);
        px_stb = 1'b1;
        x_px   = '0;
        y_px   = 10'(y);
        tick();
        px_stb = 1'b0;
    endtask

    task automatic lines(input int first, input int last);
        for (int y = first; y <= last; y++) new_line(y);
    endtask

    task automatic check(input logic [7:0] b, input logic [2:0] r, input logic [1:0] rdy);
        tick();
        exp_snap.push_back(snap_t'{b, r, rdy, 1'b0, 1'b0});
        chk = 1'b1;
        tick();
        chk = 1'b0;
    endtask

    task automatic write(input int req, input int row, input logic [7:0] data, input bit bad);
        req_valid           = (req == 0) ? 2'b01 : 2'b10;
        req_row[req*3 +: 3] = 3'(row);
        req_byte[req*8 +: 8] = data;
        exp_grant.push_back(req_valid);
        if (bad) exp_err.push_back(row);
        tick();
        req_valid = '0;
    endtask

    initial begin
        // Reset with both requesters asking: grants must stay low
        req_valid = 2'b11;
        repeat (2) tick();
        check(8'h00, 3'd0, 2'b00);
        req_valid = '0;
        tick();
        rstn = 1'b1;
        tick();

        lines(0, 160);
        check(8'h00, 3'd2, 2'b00);

        // Both valid from a fresh pointer: 0,1,0,1
        req_row   = {3'd4, 3'd5};
        req_byte  = {8'h40, 8'h50};
        req_valid = 2'b11;
        exp_grant.push_back(2'b01); tick();
        exp_grant.push_back(2'b10); tick();
        exp_grant.push_back(2'b01); tick();
        exp_grant.push_back(2'b10); tick();
        req_valid = '0;

        write(0, 2, 8'hA5, 1'b0);
        write(1, 3, 8'h11, 1'b0);
        write(0, 3, 8'h22, 1'b0);
        check(8'h00, 3'd2, 2'b00);

        exp_frame.push_back(1);
        new_line(480);
        repeat (8) tick();

        lines(0, 160);
        check(8'hA5, 3'd2, 2'b00);
        lines(161, 239);
        check(8'hA5, 3'd2, 2'b00);
        new_line(240);
        check(8'h22, 3'd3, 2'b00);

        // Out-of-range rows, including the first invalid one
        write(1, 7, 8'hFF, 1'b1);
        write(0, 6, 8'hEE, 1'b1);
        repeat (3) tick();

        // Valid held across vblank; pointer now favours requester 1
        req_row   = {3'd4, 3'd1};
        req_byte  = {8'h44, 8'h31};
        req_valid = 2'b11;
        exp_grant.push_back(2'b10); tick();
        exp_grant.push_back(2'b01); tick();
        exp_grant.push_back(2'b10); tick();
        exp_grant.push_back(2'b01);
        exp_frame.push_back(2);
        exp_gap.push_back(6);
        px_stb = 1'b1;
        x_px   = '0;
        y_px   = 10'd480;
        tick();
        px_stb = 1'b0;
        repeat (6) tick();
        exp_grant.push_back(2'b10); tick();
        exp_grant.push_back(2'b01); tick();
        exp_grant.push_back(2'b10); tick();
        exp_grant.push_back(2'b01); tick();
        req_valid = '0;
        repeat (3) tick();

        check(8'h22, 3'd3, 2'b00);
        lines(241, 320);
        check(8'h44, 3'd4, 2'b00);
        lines(321, 479);
        check(8'h50, 3'd5, 2'b00);
        lines(481, 560);
        check(8'h50, 3'd5, 2'b00);

        // Reset during the fourth commit cycle: no frame_done afterwards
        new_line(480);
        repeat (3) tick();
        rstn = 1'b0;
        tick();
        check(8'h00, 3'd0, 2'b00);
        rstn = 1'b1;
        repeat (20) tick();
        lines(0, 160);
        check(8'h00, 3'd2, 2'b00);
        repeat (4) tick();

        tests++;
        if (exp_grant.size() != 0) begin
            fails++;
            $display("FAIL grant_drain: %0d grants outstanding, expected 0", exp_grant.size());
        end
        tests++;
        if (exp_frame.size() != 0) begin
            fails++;
            $display("FAIL frame_drain: %0d frame_done pulses missing, expected 0", exp_frame.size());
        end
        tests++;
        if (exp_err.size() != 0) begin
            fails++;
            $display("FAIL err_drain: %0d row_err pulses missing, expected 0", exp_err.size());
        end
        tests++;
        if (exp_gap.size() != 0) begin
            fails++;
            $display("FAIL gap_drain: %0d stalls missing, expected 0", exp_gap.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_row_scheduler.md
LED_ROW_SCHEDULER -- requirements
Module: led_row_scheduler

Interface
REQ-001 SHALL have parameter NROWS, default 6, number of LED rows shown on screen.
REQ-002 SHALL have parameter HEIGHT, default 80, pixel lines per LED row.
REQ-003 SHALL have parameter VACTIVE, default 480, first non-active line (vblank entry).
REQ-004 SHALL have port clk  in  1  system clock; the only clock, all logic on posedge.
REQ-005 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-006 SHALL have port px_stb  in  1  one-cycle pixel strobe; pixel advances only when high.
REQ-007 SHALL have port x_px  in  10  current pixel X.
REQ-008 SHALL have port y_px  in  10  current pixel Y.
REQ-009 SHALL have port req_valid  in  2  write request per requester (0, 1).
REQ-010 SHALL have port req_row  in  6  target row, 3 bits per requester, requester 0 in [2:0].
REQ-011 SHALL have port req_byte  in  16  byte to display, 8 bits per requester, requester 0 in [7:0].
REQ-012 SHALL have port req_ready  out  2  grant; a write transfers on valid&ready in the same cycle.
REQ-013 SHALL have port byte_led  out  8  byte for the LED renderer.
REQ-014 SHALL have port row_led  out  3  row index for the LED renderer.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at end of commit.
REQ-016 SHALL have port row_err  out  1  one-cycle pulse when an accepted write has row >= NROWS.

Function
REQ-017 SHALL hold two NROWS x 8 buffers: shadow (written by requesters) and live (displayed), plus an NROWS-bit dirty mask.
REQ-018 SHALL, in state RUN, assert at most one req_ready bit per cycle, chosen round-robin: pointer starts at 0 and moves to the other requester after each transfer.
REQ-019 SHALL grant the single valid requester regardless of the pointer; with no valid, req_ready = 0.
REQ-020 SHALL, on transfer with row < NROWS, write shadow[row] <= byte and set dirty[row]; later writes to the same row before commit overwrite (last wins).
REQ-021 SHALL, on transfer with row >= NROWS, discard data, leave the buffers untouched and pulse row_err next cycle.
REQ-022 SHALL enter state COMMIT on the cycle after px_stb=1 with y_px==VACTIVE and x_px==0.
REQ-023 SHALL, in COMMIT, hold req_ready = 0 and step index i = 0..NROWS-1, one per cycle, copying shadow[i] to live[i] and clearing dirty[i] when dirty[i] is set.
REQ-024 SHALL, after i = NROWS-1, pulse frame_done for one cycle and return to RUN (COMMIT lasts exactly NROWS cycles).
REQ-025 SHALL track the display line: on px_stb with x_px==0, y_px==0 reset the line count and row count to 0; otherwise on x_px==0 increment the line count, and at HEIGHT-1 wrap it to 0 and increment the row count (saturating at NROWS-1).
REQ-026 SHALL register row_led = row count and byte_led = live[row count], so both are valid one clk after the row change.
REQ-027 SHALL ignore a vblank trigger that arrives during COMMIT.

Reset
REQ-028 SHALL, while rstn=0, clear shadow, live, dirty, row and line counts, and the RR pointer; set state = RUN; drive req_ready, byte_led, row_led, frame_done and row_err to 0.
REQ-029 SHALL, on reset mid-COMMIT, abandon the commit; no partial frame_done is produced.

Structure
REQ-030 SHALL place state encoding (RUN, COMMIT) and the requester count (2) in a shared package, alongside the renderer colour constants.
REQ-031 SHALL implement the round-robin arbiter as sub-module rr_arb2.

Verification
REQ-032 SHALL check: reset, then req0 writes row 2 = 0xA5 -> live[2] unchanged until vblank; after COMMIT, byte_led = 0xA5 while y_px in 160..239, row_led = 2.
REQ-033 SHALL check: req0 and req1 valid continuously -> grants alternate 0,1,0,1 in RUN.
REQ-034 SHALL check: row 3 written 0x11 then 0x22 before vblank -> live[3] = 0x22 after commit.
REQ-035 SHALL check: write with row = 7 -> row_err pulses once and no buffer changes.
REQ-036 SHALL check: valid held through vblank -> req_ready = 0 for exactly 6 cycles, frame_done pulses once, then grants resume.
REQ-037 SHALL check: rstn low during COMMIT cycle 3 -> all outputs 0 and no frame_done after release.
